// File: rtl/cnn_defs.sv
// cnn_defs: shared CNN accelerator types and default sizes.
// Holds the layer scheduler state encoding beside the datapath sizes.
package cnn_defs;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_NUM_FILTERS = 4;
  localparam int DEF_WADDR_WIDTH = 8;
  localparam int DEF_RUN_TIMEOUT = 64;

  typedef enum logic [2:0] {
    SCH_IDLE,
    SCH_CLR,
    SCH_LOAD,
    SCH_RUN,
    SCH_WB,
    SCH_DONE
  } sched_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_filter_scheduler_if.sv
// conv_filter_scheduler_if: ofmap writeback handshake.
// The scheduler is master; the ofmap consumer is slave.
interface conv_filter_scheduler_if #(
  parameter int IDX_W = 1
);

  logic             ofmap_valid;
  logic             ofmap_ready;
  logic [IDX_W-1:0] ofmap_filter_idx;

  modport master (
    output ofmap_valid,
    output ofmap_filter_idx,
    input  ofmap_ready
  );

  modport slave (
    input  ofmap_valid,
    input  ofmap_filter_idx,
    output ofmap_ready
  );

endinterface

// File: rtl/weight_loader.sv
// weight_loader: streams one KxK weight set out of weight memory.
// Address in cycle n, capture of that word in cycle n+1.
module weight_loader
  import cnn_defs::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int WADDR_WIDTH = DEF_WADDR_WIDTH,
  parameter int IDX_W       = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         active,
  input  logic [IDX_W-1:0]             filter_idx,
  output logic [WADDR_WIDTH-1:0]       wmem_addr,
  input  logic signed [DATA_WIDTH-1:0] wmem_rdata,
  output logic signed [DATA_WIDTH-1:0] conv_weights [KERNEL_SIZE][KERNEL_SIZE],
  output logic                         load_done
);

  localparam int K2 = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CW = $clog2(K2 + 1);

  logic [CW-1:0]          load_cnt;
  logic [CW-1:0]          cap_idx;
  logic [WADDR_WIDTH-1:0] base;

  assign base    = WADDR_WIDTH'(filter_idx) * WADDR_WIDTH'(K2);
  assign cap_idx = load_cnt - 1'b1;

  assign load_done = active && (load_cnt == CW'(K2));

  assign wmem_addr = (active && (load_cnt < CW'(K2)))
                   ? base + WADDR_WIDTH'(load_cnt)
                   : '0;

  // Step through the K^2 addresses plus one trailing capture cycle.
  always_ff @(posedge clk) begin
    if (reset || !active || load_done) begin
      load_cnt <= '0;
    end else begin
      load_cnt <= load_cnt + 1'b1;
    end
  end

  // Land the word addressed last cycle in its row-major slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          conv_weights[r][c] <= '0;
        end
      end
    end else if (active && (load_cnt != '0)) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          if (cap_idx == CW'(r * KERNEL_SIZE + c)) begin
            conv_weights[r][c] <= wmem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv_filter_scheduler.sv
// conv_filter_scheduler: runs the conv engine once per filter.
// Clear, load weights, run to done, then hand off the ofmap.
module conv_filter_scheduler
  import cnn_defs::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int WADDR_WIDTH = DEF_WADDR_WIDTH,
  parameter int RUN_TIMEOUT = DEF_RUN_TIMEOUT,
  localparam int IDX_W      = idx_w(NUM_FILTERS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         layer_done,
  output logic                         error,
  output logic [WADDR_WIDTH-1:0]       wmem_addr,
  input  logic signed [DATA_WIDTH-1:0] wmem_rdata,
  output logic signed [DATA_WIDTH-1:0] conv_weights [KERNEL_SIZE][KERNEL_SIZE],
  output logic                         conv_reset,
  output logic                         conv_en,
  input  logic                         conv_done,
  conv_filter_scheduler_if.master      wb
);

  localparam int TW = idx_w(RUN_TIMEOUT);

  sched_state_t     state;
  logic [IDX_W-1:0] filter_idx;
  logic [TW-1:0]    timer;
  logic             load_done;

  assign busy                = (state != SCH_IDLE);
  assign layer_done          = (state == SCH_DONE);
  assign conv_en             = (state == SCH_RUN);
  assign conv_reset          = reset || (state == SCH_CLR);
  assign wb.ofmap_valid      = (state == SCH_WB);
  assign wb.ofmap_filter_idx = filter_idx;

  weight_loader #(
    .DATA_WIDTH  (DATA_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE),
    .WADDR_WIDTH (WADDR_WIDTH),
    .IDX_W       (IDX_W)
  ) u_loader (
    .clk          (clk),
    .reset        (reset),
    .active       (state == SCH_LOAD),
    .filter_idx   (filter_idx),
    .wmem_addr    (wmem_addr),
    .wmem_rdata   (wmem_rdata),
    .conv_weights (conv_weights),
    .load_done    (load_done)
  );

  // Layer sequencing: filter loop, run watchdog and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SCH_IDLE;
      filter_idx <= '0;
      timer      <= '0;
      error      <= 1'b0;
    end else begin
      unique case (state)
        SCH_IDLE: begin
          if (start) begin
            state      <= SCH_CLR;
            filter_idx <= '0;
            error      <= 1'b0;
          end
        end
        SCH_CLR: begin
          state <= SCH_LOAD;
        end
        SCH_LOAD: begin
          if (load_done) begin
            state <= SCH_RUN;
            timer <= '0;
          end
        end
        SCH_RUN: begin
          if (conv_done) begin
            state <= SCH_WB;
          end else if (timer == TW'(RUN_TIMEOUT - 1)) begin
            state <= SCH_WB;
            error <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SCH_WB: begin
          if (wb.ofmap_ready) begin
            if (filter_idx == IDX_W'(NUM_FILTERS - 1)) begin
              state <= SCH_DONE;
            end else begin
              filter_idx <= filter_idx + 1'b1;
              state      <= SCH_CLR;
            end
          end
        end
        SCH_DONE: begin
          state <= SCH_IDLE;
        end
        default: begin
          state <= SCH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// tb_conv_filter_scheduler: directed and randomized layer runs.
// Expected timeline and weights come from a cycle-level model.
module tb_conv_filter_scheduler;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int NF = 2;
  localparam int AW = 8;
  localparam int RT = 64;
  localparam int K2 = K * K;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic layer_done;
  logic error;
  logic conv_reset;
  logic conv_en;
  logic conv_done;
  logic [AW-1:0] wmem_addr;
  logic signed [DW-1:0] wmem_rdata;
  logic signed [DW-1:0] conv_weights [K][K];

  conv_filter_scheduler_if #(.IDX_W(1)) wb ();

  logic [DW-1:0] mem [256];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_dly = 5;
  int ecnt;
  bit exp_err;

  conv_filter_scheduler #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (K),
    .NUM_FILTERS (NF),
    .WADDR_WIDTH (AW),
    .RUN_TIMEOUT (RT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .layer_done   (layer_done),
    .error        (error),
    .wmem_addr    (wmem_addr),
    .wmem_rdata   (wmem_rdata),
    .conv_weights (conv_weights),
    .conv_reset   (conv_reset),
    .conv_en      (conv_en),
    .conv_done    (conv_done),
    .wb           (wb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) wmem_rdata <= mem[wmem_addr];

  always @(posedge clk) begin
    if (conv_reset) begin
      ecnt      <= 0;
      conv_done <= 1'b0;
    end else if (conv_en) begin
      ecnt <= ecnt + 1;
      if (done_dly > 0 && ecnt + 1 >= done_dly) conv_done <= 1'b1;
    end
  end

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit finishes(input int d);
    return (d > 0) && (d < RT);
  endfunction

  function automatic int run_len(input int d);
    return finishes(d) ? d + 1 : RT;
  endfunction

  task automatic do_filter(input int f, input int d,
                           input int stall, input bit poke);
    int r;
    done_dly = d;
    chk("clr_reset", conv_reset, 1);
    chk("clr_busy", busy, 1);
    tick();
    for (int n = 0; n <= K2; n++) begin
      if (n < K2) chk("load_addr", wmem_addr, f * K2 + n);
      chk("load_en", conv_en, 0);
      tick();
    end
    chk("run_stale_done", conv_done, 0);
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        chk("weight", conv_weights[i][j], $signed(mem[f * K2 + i * K + j]));
      end
    end
    r = run_len(d);
    for (int c = 0; c < r; c++) begin
      chk("run_en", conv_en, 1);
      if (poke) start = (c == 1);
      tick();
    end
    if (!finishes(d)) exp_err = 1'b1;
    chk("wb_en_off", conv_en, 0);
    chk("wb_error", error, exp_err);
    for (int s = 0; s <= stall; s++) begin
      wb.ofmap_ready = (s == stall);
      chk("wb_valid", wb.ofmap_valid, 1);
      chk("wb_idx", wb.ofmap_filter_idx, f);
      tick();
    end
    wb.ofmap_ready = 1'b0;
  endtask

  task automatic run_layer(input int d [NF], input int s [NF],
                           input bit poke, input bit hold);
    int t0;
    int lat;
    lat = 0;
    for (int f = 0; f < NF; f++) lat += 1 + K2 + 1 + run_len(d[f]) + s[f] + 1;
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
    exp_err = 1'b0;
    chk("start_clears_err", error, 0);
    for (int f = 0; f < NF; f++) do_filter(f, d[f], s[f], poke && f == 0);
    if (hold) start = 1'b1;
    chk("layer_done", layer_done, 1);
    chk("latency", cyc - t0, lat);
    chk("done_err", error, exp_err);
    tick();
    chk("done_pulse", layer_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_err", error, exp_err);
  endtask

  initial begin
    int d [NF];
    int s [NF];
    for (int a = 0; a < 256; a++) mem[a] = a[DW-1:0];
    reset = 1'b1;
    start = 1'b0;
    wb.ofmap_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", layer_done, 0);
    chk("rst_error", error, 0);
    chk("rst_en", conv_en, 0);
    chk("rst_valid", wb.ofmap_valid, 0);
    chk("rst_addr", wmem_addr, 0);
    chk("rst_idx", wb.ofmap_filter_idx, 0);
    chk("rst_conv_reset", conv_reset, 1);
    chk("rst_w00", conv_weights[0][0], 0);
    reset = 1'b0;
    tick();
    chk("idle_conv_reset", conv_reset, 0);

    d = '{5, 5}; s = '{0, 0};
    run_layer(d, s, 1'b0, 1'b0);

    d = '{5, 5}; s = '{4, 0};
    run_layer(d, s, 1'b0, 1'b0);

    d = '{-1, 4}; s = '{1, 0};
    run_layer(d, s, 1'b0, 1'b0);
    tick();
    tick();
    chk("err_sticky", error, 1);

    d = '{3, 6}; s = '{0, 2};
    run_layer(d, s, 1'b1, 1'b1);
    d = '{2, 2}; s = '{0, 0};
    run_layer(d, s, 1'b0, 1'b0);

    repeat (6) begin
      for (int f = 0; f < NF; f++) begin
        d[f] = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 12));
        s[f] = int'($urandom_range(0, 4));
      end
      run_layer(d, s, 1'b0, 1'b0);
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    do_filter(0, 3, 0, 1'b0);
    chk("f1_clr", conv_reset, 1);
    tick();
    for (int n = 0; n < 3; n++) begin
      chk("f1_addr", wmem_addr, K2 + n);
      tick();
    end
    chk("abort_addr", wmem_addr, 12);
    reset = 1'b1;
    #1;
    chk("abort_conv_reset", conv_reset, 1);
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_hold_reset", conv_reset, 1);
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) chk("abort_w", conv_weights[i][j], 0);
    end
    reset = 1'b0;
    repeat (3) begin
      tick();
      chk("abort_no_done", layer_done, 0);
      chk("abort_idle", busy, 0);
    end
    d = '{4, 4}; s = '{0, 0};
    run_layer(d, s, 1'b0, 1'b0);

    for (int f = 0; f < NF; f++) begin
      for (int i = 0; i < K2; i++) mem[f * K2 + i] = 8'h80 + i[DW-1:0];
    end
    d = '{2, 3}; s = '{1, 1};
    run_layer(d, s, 1'b0, 1'b0);
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) chk("neg_w", conv_weights[i][j], -128 + i * K + j);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
